// File: rtl/bsg_manycore_hor_io_arb_pkg.sv
// Shared types and width helpers for the horizontal IO row arbiter.
package bsg_manycore_hor_io_arb_pkg;

  typedef enum logic [1:0] {
    e_run     = 2'd0,
    e_drain   = 2'd1,
    e_drained = 2'd2
  } hor_io_arb_state_e;

  // Slot layout for the default configuration; the top builds a
  // parameter-sized copy of this layout.
  localparam int hor_io_arb_row_width_gp    = 2;
  localparam int hor_io_arb_packet_width_gp = 64;

  typedef struct packed {
    logic [hor_io_arb_row_width_gp-1:0]    row;
    logic [hor_io_arb_packet_width_gp-1:0] packet;
  } hor_io_arb_slot_s;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int width_of(input int n);
    return (n <= 0) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int wrap_row(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/bsg_manycore_hor_io_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module bsg_manycore_hor_io_rr_pick
  import bsg_manycore_hor_io_arb_pkg::*;
  #(parameter int num_row_p = 4
   ,localparam int row_id_width_lp = safe_clog2(num_row_p))
  (input  logic [num_row_p-1:0]       req_i
  ,input  logic [row_id_width_lp-1:0] ptr_i
  ,output logic [num_row_p-1:0]       grant_o
  ,output logic [row_id_width_lp-1:0] idx_o
  ,output logic                       v_o
  );

  // Scan from the farthest offset back toward the pointer so the nearest hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    v_o     = 1'b0;
    for (int off = num_row_p - 1; off >= 0; off--) begin
      if (req_i[wrap_row(int'(ptr_i), off, num_row_p)]) begin
        grant_o = '0;
        grant_o[wrap_row(int'(ptr_i), off, num_row_p)] = 1'b1;
        idx_o   = row_id_width_lp'(wrap_row(int'(ptr_i), off, num_row_p));
        v_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_manycore_hor_io_row_arbiter.sv
// Round-robin, credit-limited arbiter sharing one accelerator endpoint among rows.
// Optional per-row grant counters are built when BSG_MANYCORE_HOR_IO_ARB_STATS_EN is defined.
module bsg_manycore_hor_io_row_arbiter
  import bsg_manycore_hor_io_arb_pkg::*;
  #(parameter int num_row_p = 4
   ,parameter int packet_width_p = 64
   ,parameter int max_out_credits_p = 16
   ,localparam int row_id_width_lp = safe_clog2(num_row_p)
   ,localparam int credit_width_lp = width_of(max_out_credits_p))
  (input  logic                                clk_i
  ,input  logic                                reset_n_i
  ,input  logic [num_row_p-1:0]                req_v_i
  ,input  logic [num_row_p*packet_width_p-1:0] req_packet_i
  ,output logic [num_row_p-1:0]                req_yumi_o
  ,output logic                                fwd_v_o
  ,output logic [packet_width_p-1:0]           fwd_packet_o
  ,output logic [row_id_width_lp-1:0]          fwd_row_o
  ,input  logic                                fwd_ready_i
  ,input  logic                                resp_v_i
  ,input  logic [row_id_width_lp-1:0]          resp_row_i
  ,input  logic [packet_width_p-1:0]           resp_packet_i
  ,output logic                                resp_ready_o
  ,output logic [num_row_p-1:0]                resp_v_o
  ,output logic [packet_width_p-1:0]           resp_packet_o
  ,input  logic [num_row_p-1:0]                resp_ready_i
  ,input  logic                                drain_i
  ,output logic                                drained_o
  ,output logic [credit_width_lp-1:0]          credits_o
  ,output logic                                error_o
  ,output logic [num_row_p*32-1:0]             grant_count_o
  );

  localparam logic [1:0] state_run_lp     = e_run;
  localparam logic [1:0] state_drain_lp   = e_drain;
  localparam logic [1:0] state_drained_lp = e_drained;
  localparam logic [credit_width_lp-1:0] credits_max_lp = credit_width_lp'(max_out_credits_p);

  typedef struct packed {
    logic [row_id_width_lp-1:0] row;
    logic [packet_width_p-1:0]  packet;
  } slot_s;

  slot_s                       slot_r;
  logic                        slot_v_r, slot_v_n;
  logic [credit_width_lp-1:0]  credits_r, credits_n;
  logic [row_id_width_lp-1:0]  ptr_r, ptr_n;
  logic [1:0]                  state_r, state_n;
  logic                        error_r;

  logic [num_row_p-1:0]        pick_grant;
  logic [row_id_width_lp-1:0]  pick_idx;
  logic                        pick_v;
  logic [packet_width_p-1:0]   sel_packet;
  logic                        issue_ok, grant;
  logic                        resp_in_range, resp_hs, credit_overflow;

  bsg_manycore_hor_io_rr_pick #(.num_row_p(num_row_p)) rr_pick (
    .req_i   (req_v_i),
    .ptr_i   (ptr_r),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .v_o     (pick_v)
  );

  // Draining the slot in the same cycle frees it for a refill, so no bubble.
  assign issue_ok   = (state_r == state_run_lp) & ~drain_i & (credits_r != '0)
                    & (~slot_v_r | fwd_ready_i);
  assign grant      = issue_ok & pick_v;
  assign req_yumi_o = grant ? pick_grant : '0;

  always_comb begin
    sel_packet = '0;
    for (int i = 0; i < num_row_p; i++) begin
      if (pick_idx == row_id_width_lp'(i)) begin
        sel_packet = req_packet_i[i*packet_width_p +: packet_width_p];
      end
    end
  end

  assign fwd_v_o      = slot_v_r;
  assign fwd_packet_o = slot_r.packet;
  assign fwd_row_o    = slot_r.row;

  // Out-of-range tags are accepted and dropped so a bad response cannot wedge the endpoint.
  assign resp_in_range = (int'(resp_row_i) < num_row_p);
  assign resp_packet_o = resp_packet_i;

  always_comb begin
    resp_v_o     = '0;
    resp_ready_o = ~resp_in_range;
    for (int i = 0; i < num_row_p; i++) begin
      if (resp_row_i == row_id_width_lp'(i)) begin
        resp_v_o[i]  = resp_v_i;
        resp_ready_o = resp_ready_i[i];
      end
    end
  end

  assign resp_hs         = resp_v_i & resp_ready_o;
  assign credit_overflow = resp_hs & ~grant & (credits_r == credits_max_lp);

  always_comb begin
    credits_n = credits_r;
    if (grant & ~resp_hs) begin
      credits_n = credits_r - credit_width_lp'(1);
    end else if (resp_hs & ~grant & ~credit_overflow) begin
      credits_n = credits_r + credit_width_lp'(1);
    end
  end

  assign slot_v_n = grant | (slot_v_r & ~fwd_ready_i);
  assign ptr_n    = (pick_idx == row_id_width_lp'(num_row_p - 1))
                  ? '0 : pick_idx + row_id_width_lp'(1);

  // Quiescence is judged on next-cycle slot and credit values so drained_o
  // rises the cycle right after the last outstanding response returns.
  always_comb begin
    state_n = state_r;
    case (state_r)
      state_run_lp: begin
        if (drain_i) state_n = state_drain_lp;
      end
      state_drain_lp: begin
        if (!drain_i) state_n = state_run_lp;
        else if (!slot_v_n && (credits_n == credits_max_lp)) state_n = state_drained_lp;
      end
      state_drained_lp: begin
        if (!drain_i) state_n = state_run_lp;
      end
      default: state_n = state_run_lp;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      slot_v_r  <= 1'b0;
      credits_r <= credits_max_lp;
      ptr_r     <= '0;
      state_r   <= state_run_lp;
      error_r   <= 1'b0;
    end else begin
      slot_v_r  <= slot_v_n;
      credits_r <= credits_n;
      state_r   <= state_n;
      error_r   <= error_r | credit_overflow | (resp_hs & ~resp_in_range);
      if (grant) ptr_r <= ptr_n;
    end
  end

  // Payload needs no reset; the valid bit alone discards stale contents.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      slot_r.row    <= pick_idx;
      slot_r.packet <= sel_packet;
    end
  end

  assign drained_o = (state_r == state_drained_lp);
  assign credits_o = credits_r;
  assign error_o   = error_r;

`ifdef BSG_MANYCORE_HOR_IO_ARB_STATS_EN
  logic [31:0] grant_count_r [num_row_p];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_row_p; i++) begin
      if (!reset_n_i) grant_count_r[i] <= '0;
      else if (req_yumi_o[i]) grant_count_r[i] <= grant_count_r[i] + 32'd1;
    end
  end

  always_comb begin
    grant_count_o = '0;
    for (int i = 0; i < num_row_p; i++) begin
      grant_count_o[i*32 +: 32] = grant_count_r[i];
    end
  end
`else
  assign grant_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_manycore_hor_io_row_arbiter.sv
// Self-checking bench for bsg_manycore_hor_io_row_arbiter against a cycle-level behavioural model.
module tb_bsg_manycore_hor_io_row_arbiter;

  localparam int N    = 5;
  localparam int PW   = 64;
  localparam int MAXC = 4;
  localparam int RW   = 3;
  localparam int CW   = 3;
  localparam int RUN = 0, DRAIN = 1, DRAINED = 2;

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic [N-1:0]     req_v_i;
  logic [N*PW-1:0]  req_packet_i;
  logic [N-1:0]     req_yumi_o;
  logic             fwd_v_o;
  logic [PW-1:0]    fwd_packet_o;
  logic [RW-1:0]    fwd_row_o;
  logic             fwd_ready_i;
  logic             resp_v_i;
  logic [RW-1:0]    resp_row_i;
  logic [PW-1:0]    resp_packet_i;
  logic             resp_ready_o;
  logic [N-1:0]     resp_v_o;
  logic [PW-1:0]    resp_packet_o;
  logic [N-1:0]     resp_ready_i;
  logic             drain_i;
  logic             drained_o;
  logic [CW-1:0]    credits_o;
  logic             error_o;
  logic [N*32-1:0]  grant_count_o;

  always #5 clk_i = ~clk_i;

  bsg_manycore_hor_io_row_arbiter #(
    .num_row_p(N), .packet_width_p(PW), .max_out_credits_p(MAXC)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_packet_i(req_packet_i), .req_yumi_o(req_yumi_o),
    .fwd_v_o(fwd_v_o), .fwd_packet_o(fwd_packet_o), .fwd_row_o(fwd_row_o),
    .fwd_ready_i(fwd_ready_i),
    .resp_v_i(resp_v_i), .resp_row_i(resp_row_i), .resp_packet_i(resp_packet_i),
    .resp_ready_o(resp_ready_o), .resp_v_o(resp_v_o), .resp_packet_o(resp_packet_o),
    .resp_ready_i(resp_ready_i),
    .drain_i(drain_i), .drained_o(drained_o), .credits_o(credits_o),
    .error_o(error_o), .grant_count_o(grant_count_o)
  );

  int checks = 0;
  int failures = 0;

  bit          m_known = 1'b0;
  bit          m_slot_v;
  int          m_slot_row;
  logic [PW-1:0] m_slot_pkt;
  int          m_credits;
  int          m_ptr;
  int          m_mode;
  bit          m_error;
  int unsigned m_count [N];

  task automatic checkOutput(input string tag, input logic [N*32-1:0] observed,
                             input logic [N*32-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic randomizePackets();
    for (int i = 0; i < N; i++) req_packet_i[i*PW +: PW] = {$urandom, $urandom};
    resp_packet_i = {$urandom, $urandom};
  endtask

  // Checks outputs for the current inputs, then advances the model across one clock edge.
  task automatic applyStimulus();
    int pick;
    bit in_range, e_rr, hs;
    logic [N-1:0] e_yumi, e_rv;
    logic [N*32-1:0] e_cnt;
    #1;
    pick = -1;
    if (m_known && reset_n_i && m_mode == RUN && !drain_i && m_credits > 0
        && (!m_slot_v || fwd_ready_i)) begin
      for (int k = 0; k < N && pick < 0; k++)
        if (req_v_i[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
    end
    e_yumi = '0;
    if (pick >= 0) e_yumi[pick] = 1'b1;
    in_range = (int'(resp_row_i) < N);
    e_rv = '0;
    if (resp_v_i && in_range) e_rv[resp_row_i] = 1'b1;
    e_rr = in_range ? resp_ready_i[resp_row_i] : 1'b1;
    hs = resp_v_i && e_rr;
    e_cnt = '0;
`ifdef BSG_MANYCORE_HOR_IO_ARB_STATS_EN
    for (int i = 0; i < N; i++) e_cnt[i*32 +: 32] = m_count[i];
`endif
    if (m_known && reset_n_i) begin
      checkOutput("req_yumi", req_yumi_o, e_yumi);
      checkOutput("fwd_v", fwd_v_o, m_slot_v);
      if (m_slot_v) begin
        checkOutput("fwd_packet", fwd_packet_o, m_slot_pkt);
        checkOutput("fwd_row", fwd_row_o, m_slot_row);
      end
      checkOutput("credits", credits_o, m_credits);
      checkOutput("error", error_o, m_error);
      checkOutput("drained", drained_o, m_mode == DRAINED);
      checkOutput("resp_v", resp_v_o, e_rv);
      checkOutput("resp_ready", resp_ready_o, e_rr);
      checkOutput("resp_packet", resp_packet_o, resp_packet_i);
      checkOutput("grant_count", grant_count_o, e_cnt);
    end
    @(posedge clk_i);
    if (!reset_n_i) begin
      m_known = 1'b1; m_slot_v = 1'b0; m_credits = MAXC; m_ptr = 0;
      m_mode = RUN; m_error = 1'b0;
      for (int i = 0; i < N; i++) m_count[i] = 0;
    end else if (m_known) begin
      if (hs && !in_range) m_error = 1'b1;
      if (pick >= 0 && !hs) m_credits--;
      else if (hs && pick < 0) begin
        if (m_credits == MAXC) m_error = 1'b1;
        else m_credits++;
      end
      if (pick >= 0) begin
        m_slot_v = 1'b1; m_slot_row = pick;
        m_slot_pkt = req_packet_i[pick*PW +: PW];
        m_ptr = (pick + 1) % N;
        m_count[pick]++;
      end else if (fwd_ready_i) begin
        m_slot_v = 1'b0;
      end
      case (m_mode)
        RUN:     if (drain_i) m_mode = DRAIN;
        DRAIN:   if (!drain_i) m_mode = RUN;
                 else if (!m_slot_v && m_credits == MAXC) m_mode = DRAINED;
        default: if (!drain_i) m_mode = RUN;
      endcase
    end
    @(negedge clk_i);
  endtask

  task automatic returnCredits();
    req_v_i = '0; resp_v_i = 1'b1; resp_row_i = 3'd2; resp_ready_i = 5'b00100;
    for (int i = 0; i < 2 * MAXC && m_credits < MAXC; i++) applyStimulus();
    resp_v_i = 1'b0; resp_ready_i = '1;
  endtask

  initial begin
    reset_n_i = 1'b0; req_v_i = '0; fwd_ready_i = 1'b1; resp_v_i = 1'b0;
    resp_row_i = '0; resp_ready_i = '1; drain_i = 1'b0;
    randomizePackets();
    @(negedge clk_i);
    applyStimulus(); applyStimulus();
    reset_n_i = 1'b1;
    applyStimulus();

    // Round robin with a response every cycle
    req_v_i = '1; resp_v_i = 1'b1; resp_row_i = 3'd0;
    for (int i = 0; i < 7; i++) begin randomizePackets(); applyStimulus(); end
    resp_v_i = 1'b0;

    // Credit exhaustion, then one response re-enables a single grant
    for (int i = 0; i < 6; i++) begin randomizePackets(); applyStimulus(); end
    resp_v_i = 1'b1; resp_row_i = 3'd1; applyStimulus();
    resp_v_i = 1'b0; applyStimulus(); applyStimulus();
    returnCredits();

    // Backpressure holds the slot; release drains and refills without a bubble
    req_v_i = '1; fwd_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin randomizePackets(); applyStimulus(); end
    fwd_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin randomizePackets(); applyStimulus(); end
    req_v_i = '0; applyStimulus(); applyStimulus();
    returnCredits();

    // Out-of-range response tags and sticky error
    req_v_i = 5'b01000; applyStimulus();
    req_v_i = '0; resp_v_i = 1'b1; resp_row_i = 3'd5; resp_ready_i = '0; applyStimulus();
    resp_row_i = 3'd7; applyStimulus();
    resp_v_i = 1'b0; resp_ready_i = '1;
    for (int i = 0; i < 3; i++) applyStimulus();

    reset_n_i = 1'b0; applyStimulus(); reset_n_i = 1'b1; applyStimulus();

    // Drain with three outstanding requests
    req_v_i = '1;
    for (int i = 0; i < 3; i++) begin randomizePackets(); applyStimulus(); end
    drain_i = 1'b1; applyStimulus(); applyStimulus();
    for (int r = 0; r < 3; r++) begin
      resp_v_i = 1'b1; resp_row_i = RW'(r); applyStimulus();
      resp_v_i = 1'b0; applyStimulus();
    end
    applyStimulus();
    drain_i = 1'b0;
    for (int i = 0; i < 3; i++) begin randomizePackets(); applyStimulus(); end
    returnCredits();

    // Ten grants to row 1 for the grant counters
    reset_n_i = 1'b0; applyStimulus(); reset_n_i = 1'b1;
    req_v_i = 5'b00010; resp_v_i = 1'b1; resp_row_i = 3'd1;
    for (int i = 0; i < 10; i++) begin randomizePackets(); applyStimulus(); end
    req_v_i = '0; resp_v_i = 1'b0; applyStimulus();
    returnCredits();

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      randomizePackets();
      req_v_i      = N'($urandom);
      fwd_ready_i  = ($urandom_range(0, 3) != 0);
      resp_v_i     = ($urandom_range(0, 2) == 0);
      resp_row_i   = RW'($urandom_range(0, 7));
      resp_ready_i = N'($urandom);
      if (i % 40 == 0) drain_i = ($urandom_range(0, 3) == 0);
      reset_n_i    = ($urandom_range(0, 99) != 0);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
